// File: rtl/rv_stream_demux.sv
// Per-lane valid/ready demultiplexer: one producer per lane fans out to NUM_OUTS consumers.
// Optional per-lane stall counters on perf_stalls when RV_STREAM_DEMUX_STALL_CNT_EN is defined.

module rv_stream_demux_buf #(
  parameter int BUFFERED = 1,
  parameter int DATAW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [DATAW-1:0] push_data,
  output logic             rdy,
  output logic             vld,
  output logic [DATAW-1:0] data,
  input  logic             pop_rdy
);
  if (BUFFERED == 1) begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t           state, state_nx;
    logic [DATAW-1:0] d0, d1;
    logic             push, pop;

    // rdy depends only on the state register, so ready_out never reaches ready_in
    assign rdy  = (state != FULL);
    assign vld  = (state != EMPTY);
    assign data = d0;
    assign push = req && rdy;
    assign pop  = vld && pop_rdy;

    always_ff @(posedge clk or negedge reset)
      if (!reset) state <= EMPTY;
      else        state <= state_nx;

    always_comb begin
      state_nx = state;
      case (state)
        EMPTY:   if (push) state_nx = ONE;
        ONE:     if (push && !pop) state_nx = FULL;
                 else if (pop && !push) state_nx = EMPTY;
        FULL:    if (pop) state_nx = ONE;
        default: state_nx = EMPTY;
      endcase
    end

    always_ff @(posedge clk)
      case (state)
        EMPTY:   if (push) d0 <= push_data;
        ONE:     if (push && pop) d0 <= push_data;
                 else if (push) d1 <= push_data;
        FULL:    if (pop) d0 <= d1;
        default: ;
      endcase
  end else if (BUFFERED == 2) begin : g_reg
    logic             v;
    logic [DATAW-1:0] q;
    logic             push;

    assign rdy  = !v || pop_rdy;
    assign push = req && rdy;
    assign vld  = v;
    assign data = q;

    always_ff @(posedge clk or negedge reset)
      if (!reset)       v <= 1'b0;
      else if (push)    v <= 1'b1;
      else if (pop_rdy) v <= 1'b0;

    always_ff @(posedge clk)
      if (push) q <= push_data;
  end else begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, reset};
    assign rdy  = pop_rdy;
    assign vld  = req;
    assign data = push_data;
  end
endmodule

module rv_stream_demux #(
  parameter int NUM_OUTS = 4,
  parameter int LANES    = 1,
  parameter int DATAW    = 8,
  parameter int BUFFERED = 1,
  parameter int SELW     = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LANES-1:0]                  valid_in,
  input  logic [LANES*SELW-1:0]             sel_in,
  input  logic [LANES*DATAW-1:0]            data_in,
  output logic [LANES-1:0]                  ready_in,
  output logic [NUM_OUTS*LANES-1:0]         valid_out,
  output logic [NUM_OUTS*LANES*DATAW-1:0]   data_out,
  input  logic [NUM_OUTS*LANES-1:0]         ready_out
`ifdef RV_STREAM_DEMUX_STALL_CNT_EN
  ,
  output logic [32*LANES-1:0]               perf_stalls
`endif
);
  logic [NUM_OUTS-1:0][LANES-1:0]            req, rdy, vo, ro;
  logic [NUM_OUTS-1:0][LANES-1:0][DATAW-1:0] dq;
  logic [LANES-1:0][SELW-1:0]                sel;

  assign ro        = ready_out;
  assign valid_out = vo;
  assign data_out  = dq;

  always_comb begin
    sel = '0;
    for (int i = 0; i < LANES; i++)
      if (NUM_OUTS > 1) sel[i] = sel_in[i*SELW +: SELW];
  end

  // an out-of-range select matches no output: ready stays 1 and the beat is dropped
  always_comb begin
    req      = '0;
    ready_in = '1;
    for (int i = 0; i < LANES; i++)
      for (int o = 0; o < NUM_OUTS; o++)
        if (sel[i] == SELW'(o)) begin
          req[o][i]   = valid_in[i];
          ready_in[i] = rdy[o][i];
        end
  end

  for (genvar o = 0; o < NUM_OUTS; o++) begin : g_out
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      rv_stream_demux_buf #(.BUFFERED(BUFFERED), .DATAW(DATAW)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .req       (req[o][i]),
        .push_data (data_in[i*DATAW +: DATAW]),
        .rdy       (rdy[o][i]),
        .vld       (vo[o][i]),
        .data      (dq[o][i]),
        .pop_rdy   (ro[o][i])
      );
    end
  end

`ifdef RV_STREAM_DEMUX_STALL_CNT_EN
  logic [LANES-1:0][31:0] stall_q;
  assign perf_stalls = stall_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset) stall_q <= '0;
    else
      for (int i = 0; i < LANES; i++)
        if (valid_in[i] && !ready_in[i] && stall_q[i] != 32'hFFFF_FFFF)
          stall_q[i] <= stall_q[i] + 32'd1;
`endif
endmodule
